// File: rtl/ysyx_23060229_pkg.sv
// Shared types and constants for the ysyx_23060229 multi-cycle controller.
package ysyx_23060229_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_IWAIT = 3'd1,
    S_EXEC  = 3'd2,
    S_MREQ  = 3'd3,
    S_MWAIT = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  localparam logic [2:0] CAUSE_NONE     = 3'd0;
  localparam logic [2:0] CAUSE_FETCH    = 3'd1;
  localparam logic [2:0] CAUSE_LSU      = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT  = 3'd3;
  localparam logic [2:0] CAUSE_MISALIGN = 3'd4;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060229_wdt.sv
// Clearable bus-response timeout counter; expire_c flags the last allowed wait cycle.
module ysyx_23060229_wdt #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire_c
);

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !expire_c) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire_c = inc && (cnt == LAST);

endmodule

// File: rtl/ysyx_23060229_ctrl.sv
// Multi-cycle fetch/execute/memory/write-back sequencer with sticky trap reporting.
// Optional bus-response timeout enabled by YSYX_23060229_BUS_TIMEOUT_EN.
module ysyx_23060229_ctrl
  import ysyx_23060229_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned     TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_data,
  input  logic            ifu_rsp_err,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  input  logic            dec_mem_ren,
  input  logic            dec_mem_wen,
  input  logic            dec_reg_wen,
  input  logic [1:0]      dec_csreg_wen,
  input  logic [XLEN-1:0] exu_pc_next,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_rsp_valid,
  input  logic            lsu_rsp_err,
  output logic            reg_wen,
  output logic [1:0]      csreg_wen,
  output logic            commit,
  output logic [31:0]     commit_cnt,
  output logic            trap,
  output logic [2:0]      trap_cause
);

  state_t     state;
  logic       halt_c;
  logic [2:0] halt_cause_c;
  logic       timeout_c;

  assign ifu_req_addr = pc;

`ifdef YSYX_23060229_BUS_TIMEOUT_EN
  logic wdt_clr_c;
  logic wdt_inc_c;

  // Restart the count on every request handshake that leads into a wait state.
  assign wdt_clr_c = ((state == S_FETCH) && !misaligned(pc[1:0]) && ifu_req_ready) ||
                     ((state == S_MREQ) && lsu_req_ready);
  assign wdt_inc_c = (state == S_IWAIT) || (state == S_MWAIT);

  ysyx_23060229_wdt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdt (
    .clk     (clk),
    .rst_n   (rst),
    .clr     (wdt_clr_c),
    .inc     (wdt_inc_c),
    .expire_c(timeout_c)
  );
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYC);
  assign timeout_c      = 1'b0;
`endif

  // Fatal conditions that divert the current state into HALT.
  always_comb begin
    halt_c       = 1'b0;
    halt_cause_c = CAUSE_NONE;
    case (state)
      S_FETCH: begin
        if (misaligned(pc[1:0])) begin
          halt_c       = 1'b1;
          halt_cause_c = CAUSE_MISALIGN;
        end
      end
      S_IWAIT: begin
        if (ifu_rsp_valid && ifu_rsp_err) begin
          halt_c       = 1'b1;
          halt_cause_c = CAUSE_FETCH;
        end else if (!ifu_rsp_valid && timeout_c) begin
          halt_c       = 1'b1;
          halt_cause_c = CAUSE_TIMEOUT;
        end
      end
      S_MWAIT: begin
        if (lsu_rsp_valid && lsu_rsp_err) begin
          halt_c       = 1'b1;
          halt_cause_c = CAUSE_LSU;
        end else if (!lsu_rsp_valid && timeout_c) begin
          halt_c       = 1'b1;
          halt_cause_c = CAUSE_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // State register and registered outputs; write enables and commit are set on WB entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_FETCH;
      pc            <= RESET_PC;
      inst          <= NOP_INST;
      ifu_req_valid <= !misaligned(RESET_PC[1:0]);
      lsu_req_valid <= 1'b0;
      reg_wen       <= 1'b0;
      csreg_wen     <= 2'b00;
      commit        <= 1'b0;
      commit_cnt    <= 32'd0;
      trap          <= 1'b0;
      trap_cause    <= CAUSE_NONE;
    end else begin
      reg_wen   <= 1'b0;
      csreg_wen <= 2'b00;
      commit    <= 1'b0;
      if (halt_c) begin
        state         <= S_HALT;
        trap          <= 1'b1;
        trap_cause    <= halt_cause_c;
        ifu_req_valid <= 1'b0;
        lsu_req_valid <= 1'b0;
      end else begin
        case (state)
          S_FETCH: begin
            if (ifu_req_ready) begin
              state         <= S_IWAIT;
              ifu_req_valid <= 1'b0;
            end
          end
          S_IWAIT: begin
            if (ifu_rsp_valid) begin
              inst  <= ifu_rsp_data;
              state <= S_EXEC;
            end
          end
          S_EXEC: begin
            if (dec_mem_ren || dec_mem_wen) begin
              state         <= S_MREQ;
              lsu_req_valid <= 1'b1;
            end else begin
              state      <= S_WB;
              reg_wen    <= dec_reg_wen;
              csreg_wen  <= dec_csreg_wen;
              commit     <= 1'b1;
              commit_cnt <= commit_cnt + 32'd1;
            end
          end
          S_MREQ: begin
            if (lsu_req_ready) begin
              state         <= S_MWAIT;
              lsu_req_valid <= 1'b0;
            end
          end
          S_MWAIT: begin
            if (lsu_rsp_valid) begin
              state      <= S_WB;
              reg_wen    <= dec_reg_wen;
              csreg_wen  <= dec_csreg_wen;
              commit     <= 1'b1;
              commit_cnt <= commit_cnt + 32'd1;
            end
          end
          S_WB: begin
            // A misaligned target never raises a fetch request; FETCH traps on it instead.
            pc            <= exu_pc_next;
            state         <= S_FETCH;
            ifu_req_valid <= !misaligned(exu_pc_next[1:0]);
          end
          S_HALT: begin
            state <= S_HALT;
          end
          default: begin
            state <= S_HALT;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ysyx_23060229_ctrl.md
# ysyx_23060229_ctrl

Multi-cycle sequencing controller that replaces the single-cycle core top. It drives instruction fetch and load/store through valid/ready bus handshakes, holds the fetched instruction stable for IDU/EXU, and gates register and CSR write-back to one commit cycle per instruction. It sits between the decode/execute datapath and the instruction/data memory ports, and reports retirement and fatal bus traps.

## Interface
- XLEN, 32, width of PC and addresses
- RESET_PC, 32'h8000_0000, PC loaded on reset
- TIMEOUT_CYC, 255, max wait cycles for a bus response (used only with the timeout macro)

- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- ifu_req_valid  out  1  fetch request
- ifu_req_ready  in  1  fetch request accepted
- ifu_req_addr  out  XLEN  fetch address, always equal to pc
- ifu_rsp_valid  in  1  fetch data valid
- ifu_rsp_data  in  32  fetched instruction
- ifu_rsp_err  in  1  fetch bus error, qualified by ifu_rsp_valid
- inst  out  32  latched instruction for IDU
- pc  out  XLEN  current PC
- dec_mem_ren, dec_mem_wen  in  1 each  IDU load/store flags for inst
- dec_reg_wen  in  1  IDU GPR write flag
- dec_csreg_wen  in  2  IDU CSR write code (01 csr op, 10 ecall)
- exu_pc_next  in  XLEN  next PC from EXU
- lsu_req_valid  out  1  load/store request
- lsu_req_ready  in  1  load/store request accepted
- lsu_rsp_valid  in  1  load data valid / store done
- lsu_rsp_err  in  1  LSU bus error, qualified by lsu_rsp_valid
- reg_wen  out  1  GPR write enable, asserted only in WB
- csreg_wen  out  2  CSR write enable, asserted only in WB
- commit  out  1  one-cycle pulse per retired instruction
- commit_cnt  out  32  retired-instruction count
- trap  out  1  sticky fatal-trap flag
- trap_cause  out  3  0 none, 1 fetch err, 2 LSU err, 3 timeout, 4 misaligned PC

## Operation
- States: FETCH, IWAIT, EXEC, MREQ, MWAIT, WB, HALT.
- FETCH:
  - If pc[1:0]!=0, go to HALT with cause 4.
  - Otherwise assert ifu_req_valid. On ifu_req_ready go to IWAIT.
- IWAIT: on ifu_rsp_valid:
  - ifu_rsp_err=1: go to HALT with cause 1.
  - Otherwise latch ifu_rsp_data into inst and go to EXEC.
- EXEC: one cycle for the decode/execute datapath to settle.
  - If dec_mem_ren or dec_mem_wen, go to MREQ.
  - Otherwise go to WB.
- MREQ: assert lsu_req_valid. On lsu_req_ready go to MWAIT.
- MWAIT: on lsu_rsp_valid:
  - lsu_rsp_err=1: go to HALT with cause 2.
  - Otherwise go to WB.
- WB:
  - reg_wen=dec_reg_wen and csreg_wen=dec_csreg_wen.
  - commit=1, commit_cnt+=1 (wraps modulo 2^32).
  - pc<=exu_pc_next, then go to FETCH.
- HALT: absorbing state.
  - trap=1, all request valids 0, all write enables 0.
  - Left only by reset.
- Outside WB: reg_wen=0 and csreg_wen=0.
- Response valids arriving outside their own wait state are ignored.
- Once a request valid is asserted, it and ifu_req_addr stay stable until the ready handshake.
- inst changes only on the IWAIT capture edge.

## Timing
- Reset values:
  - pc=RESET_PC, inst=32'h0000_0013 (nop), state=FETCH.
  - ifu_req_valid is therefore 1 as soon as reset deasserts.
  - lsu_req_valid=0, reg_wen=0, csreg_wen=0, commit=0, commit_cnt=0, trap=0, trap_cause=0.
- Request valids and write enables are Moore outputs, decoded from state only.
- Responses are accepted no earlier than the cycle after their request handshake.
- Zero-wait memory (ready=1, rsp the next cycle): non-memory instruction takes 4 cycles; load/store takes 6 cycles.
- Reset asserted mid-transaction:
  - All outputs are forced to reset values immediately.
  - A response still outstanding lands in FETCH and is ignored.

## Configuration
- YSYX_23060229_BUS_TIMEOUT_EN defined:
  - A counter clears on entry to IWAIT/MWAIT and increments each waiting cycle.
  - When it reaches TIMEOUT_CYC without a response, go to HALT with cause 3.
- Not defined: no counter exists, and IWAIT/MWAIT wait indefinitely.

## Structure
- Shared package ysyx_23060229_pkg holds:
  - state enum
  - trap-cause constants
  - NOP encoding
- One sub-module, ysyx_23060229_wdt: the clearable timeout counter with an expire output. It is instantiated only under the macro.

## Test plan
- Reset, zero-wait memory, three ALU ops with exu_pc_next=pc+4 -> commit pulses at cycles 4, 8, 12; pc=0x8000000C; commit_cnt=3.
- Load with lsu_req_ready low for 3 cycles -> lsu_req_valid held 4 cycles; reg_wen pulses once, in WB only; total latency 9 cycles.
- ifu_rsp_err=1 on the second fetch -> trap=1, cause=1, commit_cnt=1, no further request valids.
- exu_pc_next=0x80000002 -> next FETCH enters HALT with cause 4, and ifu_req_valid is never asserted for that address.
- With the macro and TIMEOUT_CYC=8, no ifu_rsp_valid -> HALT with cause 3 after 8 IWAIT cycles. Without the macro -> still in IWAIT after 1000 cycles.
- Reset asserted in MWAIT, then a late lsu_rsp_valid -> ignored; pc=RESET_PC; fetch restarts.
